// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and scan-code decoder.
// Byte values are scan code set 2 prefixes and keyboard-to-host responses.
package ps2_pkg;

    localparam logic [7:0] BYTE_EXT    = 8'hE0;
    localparam logic [7:0] BYTE_BRK    = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE  = 8'hE1;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_ERR_LO = 8'h00;
    localparam logic [7:0] BYTE_ERR_HI = 8'hFF;

    // Pause sends E1 followed by seven more bytes that carry no key information.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_TOGGLE   = 10;
    localparam int KEY_PRESSED  = 9;
    localparam int KEY_EXTENDED = 8;

    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_DATA,
        FRAME_PARITY,
        FRAME_STOP
    } frame_state_e;

    function automatic logic is_device_response(input logic [7:0] b);
        return b inside {BYTE_ACK, BYTE_BAT_OK, BYTE_ECHO, BYTE_RESEND, BYTE_ERR_LO, BYTE_ERR_HI};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and deglitches the pins, deserialises
// start/8 data/odd parity/stop frames and aborts frames that stall.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       rx_abort
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    frame_state_e           state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_ok_q, par_ok_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic clk_s, data_s, fall;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign rx_byte = shift_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clk_sync_d     = clk_sync_q << 1;
        clk_sync_d[0]  = ps2_clk;
        data_sync_d    = data_sync_q << 1;
        data_sync_d[0] = ps2_data;

        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_MAX) filt_d = clk_s;
            else                        filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rx_abort  = 1'b0;

        // A falling edge always beats a simultaneous timeout.
        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                FRAME_IDLE: begin
                    if (!data_s) begin
                        state_d   = FRAME_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        rx_error = 1'b1;
                    end
                end
                FRAME_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = FRAME_PARITY;
                end
                FRAME_PARITY: begin
                    par_ok_d = ^{shift_q, data_s};
                    state_d  = FRAME_STOP;
                end
                FRAME_STOP: begin
                    if (data_s && par_ok_q) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_error = 1'b1;
                        rx_abort = 1'b1;
                    end
                    state_d = FRAME_IDLE;
                end
                default: state_d = FRAME_IDLE;
            endcase
        end else if (state_q != FRAME_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d  = FRAME_IDLE;
                tmo_d    = '0;
                rx_error = 1'b1;
                rx_abort = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // NOTE: synchronisers and filter reset to 1 so leaving reset never looks like a falling edge.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            state_q     <= FRAME_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to toggle-style key event word: frame receiver plus a
// scan-code decoder tracking the E0/F0 prefixes and the Pause sequence.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_error
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_error, rx_abort;

    logic [10:0] key_q, key_d;
    logic        err_q, err_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [2:0]  skip_q, skip_d;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .rx_abort(rx_abort)
    );

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        err_d  = rx_error;

        if (rx_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == BYTE_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == BYTE_BRK) begin
                brk_d = 1'b1;
            end else if (rx_byte == BYTE_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (!(is_device_response(rx_byte) && !ext_q && !brk_q)) begin
                key_d[KEY_TOGGLE]   = ~key_q[KEY_TOGGLE];
                key_d[KEY_PRESSED]  = ~brk_q;
                key_d[KEY_EXTENDED] = ext_q;
                key_d[7:0]          = rx_byte;
                ext_d               = 1'b0;
                brk_d               = 1'b0;
            end
        end else if (rx_abort) begin
            // A damaged frame may have been the key a prefix belonged to.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= 11'h000;
            err_q  <= 1'b0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
        end else begin
            key_q  <= key_d;
            err_q  <= err_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key     = key_q;
    assign frame_error = err_q;

endmodule
